hazard_scoreboard_unit: RTL and testbench
=========================================

# hazard_scoreboard_unit

Parametrised successor to the pipeline hazard detector for the multi-core RISC-V datapath. It replaces the single-cycle load-use compare with a per-register busy scoreboard, so loads of any latency (cache miss, coherence stall) hold dependent instructions in decode until writeback. It also bounds the number of in-flight loads and holds branch/jump flush until the fetch stage acknowledges the redirect. It sits beside the decode stage of each core and drives the pipeline-latch stall and flush controls.

## Interface
- NREGS, default 32: architectural registers; register 0 is never busy.
- REG_W, default 5: register index width, $clog2(NREGS).
- MAX_LOADS, default 4: maximum outstanding loads (1..15).
- WB_BYPASS, default 1: 1 = a writeback clear releases a dependent in the same cycle; 0 = release one cycle later.
- CLK  in  1  core clock; all state changes on its rising edge.
- nRST  in  1  asynchronous, active-low reset.
- id_valid  in  1  a valid instruction is in decode.
- id_rs1, id_rs2  in  REG_W  decode source registers.
- id_uses_rs1, id_uses_rs2  in  1  the source operand is actually read.
- id_memRead  in  1  the decode instruction is a load.
- id_rd  in  REG_W  decode destination register.
- wb_valid  in  1  a valid instruction is in writeback.
- wb_memRead  in  1  the writeback instruction is a load.
- wb_rd  in  REG_W  writeback destination register.
- redirect  in  1  branch taken or jump resolved in execute this cycle.
- fetch_ack  in  1  fetch has accepted the redirect target (ihit on the new PC).
- stall  out  1  freeze the PC and IF/ID; insert a bubble into ID/EX.
- flush  out  1  squash the IF/ID and ID/EX contents.
- busy_vec  out  NREGS  registered scoreboard; bit 0 is always 0.
- pending_cnt  out  $clog2(MAX_LOADS+1)  count of outstanding loads.

## Operation
- Issue event: id_valid & id_memRead & !stall & !flush.
- Release event: wb_valid & wb_memRead.
- On an issue event with id_rd!=0, busy[id_rd] is set. On a release event, busy[wb_rd] is cleared.
- If issue and release hit the same register in the same cycle, set wins, because the new load is the younger writer.
- pending_cnt increments on an issue event and decrements on a release event. If both occur in the same cycle, it is unchanged. The counter never wraps: an increment at MAX_LOADS or a decrement at 0 is an error; a simulation assertion fires and the value holds.
- A hazard on rsN exists when id_uses_rsN, rsN!=0 and busy[rsN] are all true. When WB_BYPASS=1, a release to rsN in the same cycle cancels that hazard.
- A capacity hazard exists when id_memRead is true, pending_cnt==MAX_LOADS and there is no release in the same cycle.
- stall = id_valid & !flush & (any source hazard | capacity hazard).
- flush_hold state: IDLE -> HOLD when redirect & !fetch_ack; HOLD -> IDLE when fetch_ack. A redirect while in HOLD stays in HOLD.
- flush = redirect | (state==HOLD). Flush has priority over stall.
- Flush does not clear the scoreboard: loads already in execute or later remain architecturally live.

## Timing
- Reset values: busy_vec=0, pending_cnt=0, state=IDLE, flush=0 (unless redirect is high), stall=0 (unless a hazard is combinationally present; after reset no register is busy).
- stall and flush are combinational from the current inputs and registered state, with zero latency.
- busy_vec and pending_cnt update one cycle after their event.
- A dependent instruction enters execute no earlier than the cycle after the load's release (WB_BYPASS=1) or two cycles after it (WB_BYPASS=0).
- Reset asserted mid-operation clears all state immediately; in-flight loads are forgotten.

## Test plan
- Load x5 issues, then "add x6,x5,x1" in decode with the release 4 cycles later -> stall=1 for 4 cycles and 0 in the release cycle (WB_BYPASS=1); busy_vec[5] 1->0.
- Same stimulus with WB_BYPASS=0 -> stall stays 1 through the release cycle and drops the cycle after.
- MAX_LOADS=2: two independent loads issue, a third load reaches decode -> stall=1 and pending_cnt=2; on the release cycle stall=0, the third load issues and pending_cnt stays 2.
- Load to x0, then a reader of x0 -> busy_vec stays 0 and stall=0.
- redirect with fetch_ack low for 3 cycles -> flush=1 for 4 cycles total and 0 after the fetch_ack cycle; a load in decode during the flush does not increment pending_cnt.
- Issue load x7 and release load x7 in the same cycle, with pending_cnt=1 -> busy_vec[7]=1 and pending_cnt=1 afterwards; nRST low mid-sequence -> busy_vec=0, pending_cnt=0, flush=0.

Source files
------------

// File: rtl/hazard_scoreboard_unit_if.sv
// hazard_scoreboard_unit_if: decode/writeback/redirect inputs and stall/flush/scoreboard outputs of the hazard unit
interface hazard_scoreboard_unit_if #(
    parameter int NREGS     = 32,
    parameter int REG_W     = 5,
    parameter int MAX_LOADS = 4
);
    localparam int CW = $clog2(MAX_LOADS + 1);
    logic             id_valid;
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic             id_memRead;
    logic [REG_W-1:0] id_rd;
    logic             wb_valid;
    logic             wb_memRead;
    logic [REG_W-1:0] wb_rd;
    logic             redirect;
    logic             fetch_ack;
    logic             stall;
    logic             flush;
    logic [NREGS-1:0] busy_vec;
    logic [CW-1:0]    pending_cnt;
    modport master (
        output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_memRead, id_rd,
        output wb_valid, wb_memRead, wb_rd, redirect, fetch_ack,
        input  stall, flush, busy_vec, pending_cnt
    );
    modport slave (
        input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_memRead, id_rd,
        input  wb_valid, wb_memRead, wb_rd, redirect, fetch_ack,
        output stall, flush, busy_vec, pending_cnt
    );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit: per-register load scoreboard, load-capacity limit and held redirect flush for decode
module hazard_scoreboard_unit #(
    parameter int NREGS     = 32,
    parameter int REG_W     = 5,
    parameter int MAX_LOADS = 4,
    parameter int WB_BYPASS = 1
) (
    input logic                    CLK,
    input logic                    nRST,
    hazard_scoreboard_unit_if.slave bus
);
    localparam int CW = $clog2(MAX_LOADS + 1);
    localparam logic [CW-1:0] MAXC = CW'(MAX_LOADS);
    localparam logic BYP = (WB_BYPASS != 0);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t           r_state;
    logic [NREGS-1:0] r_busy;
    logic [CW-1:0]    r_cnt;
    logic [NREGS-1:0] w_busy_nx;
    logic [CW-1:0]    w_cnt_nx;
    logic             w_rel, w_issue, w_haz1, w_haz2, w_cap, w_stall, w_flush;

    assign w_rel   = bus.wb_valid & bus.wb_memRead;
    assign w_haz1  = bus.id_uses_rs1 && bus.id_rs1 != '0 && r_busy[bus.id_rs1]
                     && !(BYP && w_rel && bus.wb_rd == bus.id_rs1);
    assign w_haz2  = bus.id_uses_rs2 && bus.id_rs2 != '0 && r_busy[bus.id_rs2]
                     && !(BYP && w_rel && bus.wb_rd == bus.id_rs2);
    assign w_cap   = bus.id_memRead && r_cnt == MAXC && !w_rel;
    assign w_flush = bus.redirect | (r_state == HOLD);
    assign w_stall = bus.id_valid & !w_flush & (w_haz1 | w_haz2 | w_cap);
    assign w_issue = bus.id_valid & bus.id_memRead & !w_stall & !w_flush;

    // set after clear: a same-cycle issue is the younger writer of that register
    always_comb begin
        w_busy_nx = r_busy;
        if (w_rel) w_busy_nx[bus.wb_rd] = 1'b0;
        if (w_issue && bus.id_rd != '0) w_busy_nx[bus.id_rd] = 1'b1;
        w_busy_nx[0] = 1'b0;
    end

    assign w_cnt_nx = (w_issue && !w_rel && r_cnt != MAXC) ? r_cnt + 1'b1 :
                      (w_rel && !w_issue && r_cnt != '0)   ? r_cnt - 1'b1 : r_cnt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
            r_busy  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= (!bus.fetch_ack && (bus.redirect || r_state == HOLD)) ? HOLD : IDLE;
            r_busy  <= w_busy_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    // counter saturation is a protocol error upstream; value holds
    always_ff @(posedge CLK) begin
        if (nRST) begin
            assert (!(w_issue && !w_rel && r_cnt == MAXC));
            assert (!(w_rel && !w_issue && r_cnt == '0));
        end
    end

    assign bus.stall       = w_stall;
    assign bus.flush       = w_flush;
    assign bus.busy_vec    = r_busy;
    assign bus.pending_cnt = r_cnt;
endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// tb_hazard_scoreboard_unit: directed checks of two units (write-back bypass on/off) fed identical stimulus
module tb_hazard_scoreboard_unit;
    logic       CLK, nRST;
    logic       id_valid, id_uses_rs1, id_uses_rs2, id_memRead;
    logic [4:0] id_rs1, id_rs2, id_rd, wb_rd;
    logic       wb_valid, wb_memRead, redirect, fetch_ack;
    int         n_cmp = 0;
    int         n_err = 0;

    hazard_scoreboard_unit_if #(.NREGS(32), .REG_W(5), .MAX_LOADS(2)) ia ();
    hazard_scoreboard_unit_if #(.NREGS(32), .REG_W(5), .MAX_LOADS(2)) ib ();

    hazard_scoreboard_unit #(.NREGS(32), .REG_W(5), .MAX_LOADS(2), .WB_BYPASS(1))
        u_a (.CLK(CLK), .nRST(nRST), .bus(ia));
    hazard_scoreboard_unit #(.NREGS(32), .REG_W(5), .MAX_LOADS(2), .WB_BYPASS(0))
        u_b (.CLK(CLK), .nRST(nRST), .bus(ib));

    assign ia.id_valid    = id_valid;    assign ib.id_valid    = id_valid;
    assign ia.id_rs1      = id_rs1;      assign ib.id_rs1      = id_rs1;
    assign ia.id_rs2      = id_rs2;      assign ib.id_rs2      = id_rs2;
    assign ia.id_uses_rs1 = id_uses_rs1; assign ib.id_uses_rs1 = id_uses_rs1;
    assign ia.id_uses_rs2 = id_uses_rs2; assign ib.id_uses_rs2 = id_uses_rs2;
    assign ia.id_memRead  = id_memRead;  assign ib.id_memRead  = id_memRead;
    assign ia.id_rd       = id_rd;       assign ib.id_rd       = id_rd;
    assign ia.wb_valid    = wb_valid;    assign ib.wb_valid    = wb_valid;
    assign ia.wb_memRead  = wb_memRead;  assign ib.wb_memRead  = wb_memRead;
    assign ia.wb_rd       = wb_rd;       assign ib.wb_rd       = wb_rd;
    assign ia.redirect    = redirect;    assign ib.redirect    = redirect;
    assign ia.fetch_ack   = fetch_ack;   assign ib.fetch_ack   = fetch_ack;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic dec(input logic v, input logic [4:0] r1, input logic u1,
                       input logic [4:0] r2, input logic u2, input logic mr, input logic [4:0] rd);
        id_valid = v; id_rs1 = r1; id_uses_rs1 = u1; id_rs2 = r2; id_uses_rs2 = u2;
        id_memRead = mr; id_rd = rd;
    endtask

    task automatic wb(input logic v, input logic mr, input logic [4:0] rd);
        wb_valid = v; wb_memRead = mr; wb_rd = rd;
    endtask

    initial begin
        nRST = 1'b0;
        dec(0, 0, 0, 0, 0, 0, 0);
        wb(0, 0, 0);
        redirect = 0; fetch_ack = 0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_busy", ia.busy_vec, 0);
        chk("rst_cnt", ia.pending_cnt, 0);
        chk("rst_flush", ia.flush, 0);
        chk("rst_stall", ia.stall, 0);
        nRST = 1'b1;
        tick();
        // load-use: lw x5, then add x6,x5,x1 waits four cycles for the release
        dec(1, 0, 0, 0, 0, 1, 5);
        #2 chk("lu_issue_stall", ia.stall, 0);
        tick();
        chk("lu_busy5_set", ia.busy_vec[5], 1);
        chk("lu_cnt1", ia.pending_cnt, 1);
        dec(1, 5, 1, 1, 1, 0, 6);
        for (int i = 0; i < 4; i++) begin
            #2 chk("lu_stall_a", ia.stall, 1);
            chk("lu_stall_b", ib.stall, 1);
            tick();
        end
        wb(1, 1, 5);
        #2 chk("lu_rel_stall_a", ia.stall, 0);
        chk("lu_rel_stall_b", ib.stall, 1);
        tick();
        wb(0, 0, 0);
        #2 chk("lu_busy5_clr", ia.busy_vec[5], 0);
        chk("lu_after_stall_b", ib.stall, 0);
        chk("lu_cnt0", ia.pending_cnt, 0);
        dec(0, 0, 0, 0, 0, 0, 0);
        tick();
        // capacity: two loads outstanding, third waits for a release
        dec(1, 0, 0, 0, 0, 1, 10);
        tick();
        dec(1, 0, 0, 0, 0, 1, 11);
        tick();
        dec(1, 0, 0, 0, 0, 1, 12);
        #2 chk("cap_cnt2", ia.pending_cnt, 2);
        chk("cap_stall_a", ia.stall, 1);
        chk("cap_stall_b", ib.stall, 1);
        tick();
        #2 chk("cap_stall_hold", ia.stall, 1);
        wb(1, 1, 10);
        #1 chk("cap_rel_stall_a", ia.stall, 0);
        chk("cap_rel_stall_b", ib.stall, 0);
        tick();
        wb(0, 0, 0);
        dec(0, 0, 0, 0, 0, 0, 0);
        chk("cap_cnt_same", ia.pending_cnt, 2);
        chk("cap_busy_12_10", ia.busy_vec[12:10], 3'b110);
        chk("cap_cnt_b", ib.pending_cnt, 2);
        wb(1, 1, 11);
        tick();
        wb(1, 1, 12);
        tick();
        wb(0, 0, 0);
        chk("cap_drain", ia.pending_cnt, 0);
        chk("cap_drain_busy", ia.busy_vec, 0);
        // x0 is never busy
        dec(1, 0, 0, 0, 0, 1, 0);
        tick();
        chk("x0_busy", ia.busy_vec, 0);
        chk("x0_cnt", ia.pending_cnt, 1);
        dec(1, 0, 1, 0, 1, 0, 3);
        wb(1, 1, 0);
        #2 chk("x0_stall", ia.stall, 0);
        tick();
        dec(0, 0, 0, 0, 0, 0, 0);
        wb(0, 0, 0);
        chk("x0_cnt_clr", ia.pending_cnt, 0);
        // redirect held until fetch_ack; a load under flush does not issue
        redirect = 1;
        #2 chk("fl_f0", ia.flush, 1);
        tick();
        redirect = 0;
        dec(1, 0, 0, 0, 0, 1, 9);
        #2 chk("fl_f1", ia.flush, 1);
        chk("fl_f1_stall", ia.stall, 0);
        tick();
        dec(0, 0, 0, 0, 0, 0, 0);
        #2 chk("fl_f2", ia.flush, 1);
        chk("fl_no_issue", ia.pending_cnt, 0);
        tick();
        fetch_ack = 1;
        #2 chk("fl_f3_ack", ia.flush, 1);
        tick();
        fetch_ack = 0;
        #2 chk("fl_f4_idle", ia.flush, 0);
        chk("fl_cnt", ia.pending_cnt, 0);
        tick();
        // same-register issue and release: set wins, count unchanged
        dec(1, 0, 0, 0, 0, 1, 7);
        tick();
        wb(1, 1, 7);
        #2 chk("sr_cnt_before", ia.pending_cnt, 1);
        tick();
        dec(0, 0, 0, 0, 0, 0, 0);
        wb(0, 0, 0);
        chk("sr_busy7", ia.busy_vec[7], 1);
        chk("sr_cnt", ia.pending_cnt, 1);
        redirect = 1;
        tick();
        redirect = 0;
        #2 chk("sr_hold", ia.flush, 1);
        nRST = 1'b0;
        #1 chk("mr_busy", ia.busy_vec, 0);
        chk("mr_cnt", ia.pending_cnt, 0);
        chk("mr_flush", ia.flush, 0);
        chk("mr_busy_b", ib.busy_vec, 0);
        tick();
        nRST = 1'b1;
        tick();
        chk("mr_flush_after", ia.flush, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
